// File: rtl/mac_secuencial_pkg.sv
// Fixed-point definitions shared by the MAC datapath and the truncation stage downstream.
// Q4.19 samples and coefficients; the 2N-bit sum keeps FA+FB fraction bits.
package pkg_punto_fijo;

    localparam int N  = 24;
    localparam int FA = 19;
    localparam int FB = 19;

    localparam logic signed [2*N-1:0] SAT_POS = {2'b00, {(2*N-2){1'b1}}};
    localparam logic signed [2*N-1:0] SAT_NEG = {2'b11, {(2*N-2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACUM  = 2'd1,
        DRAIN = 2'd2
    } estado_t;

endpackage

// File: rtl/mac_secuencial_sat_sumador.sv
// Combinational (2N+1)-bit signed add with clamp to the 2N-1-bit signed range.
// The clamped result is sign-extended back to 2N bits; ovf flags any clamp.
module sat_sumador #(
    parameter int N = 24
) (
    input  logic signed [2*N-1:0] a,
    input  logic signed [2*N-1:0] b,
    output logic signed [2*N-1:0] suma,
    output logic                  ovf
);

    localparam logic signed [2*N:0] LIM_POS = {3'b000, {(2*N-2){1'b1}}};
    localparam logic signed [2*N:0] LIM_NEG = {3'b111, {(2*N-2){1'b0}}};

    logic signed [2*N:0] bruto;

    assign bruto = {a[2*N-1], a} + {b[2*N-1], b};

    always_comb begin
        ovf  = 1'b0;
        suma = bruto[2*N-1:0];
        if (bruto > LIM_POS) begin
            suma = LIM_POS[2*N-1:0];
            ovf  = 1'b1;
        end else if (bruto < LIM_NEG) begin
            suma = LIM_NEG[2*N-1:0];
            ovf  = 1'b1;
        end
    end

endmodule

// File: rtl/mac_secuencial.sv
// Sequential signed MAC: TAPS pairs per frame, one registered product, saturating accumulator.
// Emits the clamped 2N-bit frame sum with a one-cycle sum_valid and a per-frame sat_flag.
module mac_secuencial #(
    parameter int N    = pkg_punto_fijo::N,
    parameter int TAPS = 8,
    parameter int CW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   Dato_A,
    input  logic [N-1:0]   Dato_B,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*N-1:0] Datos_Sum,
    output logic           sum_valid,
    output logic           sat_flag
);

    import pkg_punto_fijo::*;

    estado_t                estado;
    logic [CW-1:0]          cnt;
    logic signed [2*N-1:0]  a_ext;
    logic signed [2*N-1:0]  b_ext;
    logic signed [2*N-1:0]  prod_q;
    logic                   vld_p0;
    logic signed [2*N-1:0]  acc_p1;
    logic                   sticky_sat;
    logic signed [2*N-1:0]  suma;
    logic                   ovf;
    logic                   acepta;

    assign in_ready = (estado != DRAIN);
    assign acepta   = in_valid && in_ready;
    assign a_ext    = {{N{Dato_A[N-1]}}, Dato_A};
    assign b_ext    = {{N{Dato_B[N-1]}}, Dato_B};

    sat_sumador #(.N(N)) u_sat_sumador (
        .a    (acc_p1),
        .b    (prod_q),
        .suma (suma),
        .ovf  (ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= IDLE;
            cnt        <= '0;
            prod_q     <= '0;
            vld_p0     <= 1'b0;
            acc_p1     <= '0;
            sticky_sat <= 1'b0;
            Datos_Sum  <= '0;
            sum_valid  <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            // Stage 0: product of the accepted pair; vld_p0 marks it as pending for the adder
            if (acepta) begin
                prod_q <= a_ext * b_ext;
            end
            vld_p0    <= acepta;
            sum_valid <= 1'b0;

            // Stage 1: accumulate the pending product, close the frame in DRAIN
            unique case (estado)
                IDLE: begin
                    acc_p1 <= '0;
                    cnt    <= '0;
                    if (acepta) begin
                        cnt    <= CW'(1);
                        estado <= (TAPS == 1) ? DRAIN : ACUM;
                    end
                end
                ACUM: begin
                    if (vld_p0) begin
                        acc_p1     <= suma;
                        sticky_sat <= sticky_sat | ovf;
                    end
                    if (acepta) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(TAPS - 1)) begin
                            estado <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    Datos_Sum  <= suma;
                    sat_flag   <= sticky_sat | ovf;
                    sum_valid  <= 1'b1;
                    acc_p1     <= '0;
                    cnt        <= '0;
                    sticky_sat <= 1'b0;
                    estado     <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_secuencial.sv
// Bench for mac_secuencial (N=24, TAPS=4): directed frames plus random frames against a
// frame-level reference that sums exact products with per-step clamping.
module tb_mac_secuencial;

    localparam int N    = 24;
    localparam int TAPS = 4;

    localparam longint POS = (64'sd1 <<< 46) - 1;
    localparam longint NEG = -(64'sd1 <<< 46);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   Dato_A = '0;
    logic [N-1:0]   Dato_B = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*N-1:0] Datos_Sum;
    logic           sum_valid;
    logic           sat_flag;

    mac_secuencial #(.N(N), .TAPS(TAPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .Dato_A    (Dato_A),
        .Dato_B    (Dato_B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Datos_Sum (Datos_Sum),
        .sum_valid (sum_valid),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    longint         prods[$];
    logic [2*N-1:0] exp_sum_q[$];
    logic           exp_sat_q[$];
    int             exp_cyc_q[$];
    int             pulse_q[$];
    logic [2*N-1:0] last_sum = '0;
    logic           last_sat = 1'b0;
    logic           prev_sv = 1'b0;
    int             drain_cyc = -1;

    task automatic model_frame(input int k);
        longint acc = 0;
        logic   sat = 1'b0;
        foreach (prods[i]) begin
            acc = acc + prods[i];
            if (acc > POS) begin acc = POS; sat = 1'b1; end
            if (acc < NEG) begin acc = NEG; sat = 1'b1; end
        end
        exp_sum_q.push_back(acc[2*N-1:0]);
        exp_sat_q.push_back(sat);
        exp_cyc_q.push_back(k + 1);
        drain_cyc = k;
        prods.delete();
    endtask

    task automatic put_pair(input logic [N-1:0] a, input logic [N-1:0] b);
        logic ok;
        int   waited = 0;
        Dato_A   = a;
        Dato_B   = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 64'd1, 64'd0);
                in_valid = 1'b0;
                return;
            end
        end
        #1;
        in_valid = 1'b0;
        prods.push_back(longint'($signed(a)) * longint'($signed(b)));
        if (prods.size() == TAPS) model_frame(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        prods.delete();
        exp_sum_q.delete();
        exp_sat_q.delete();
        exp_cyc_q.delete();
        last_sum  = '0;
        last_sat  = 1'b0;
        prev_sv   = 1'b0;
        drain_cyc = -1;
        #1;
        chk("rst_sum", Datos_Sum, '0);
        chk("rst_valid", sum_valid, 1'b0);
        chk("rst_sat", sat_flag, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        idle(3);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic frame1(input int gap);
        put_pair(24'h080000, 24'h080000); idle(gap);
        put_pair(24'h100000, 24'h040000); idle(gap);
        put_pair(24'hF80000, 24'h180000); idle(gap);
        put_pair(24'h040000, 24'h040000);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_sum_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        chk("pending_frames", exp_sum_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("sv_twice", prev_sv && sum_valid, 1'b0);
            chk("in_ready", in_ready, cyc != drain_cyc);
            if (sum_valid) begin
                pulse_q.push_back(cyc);
                if (exp_sum_q.size() == 0) begin
                    chk("unexpected_sv", 1'b1, 1'b0);
                end else begin
                    last_sum = exp_sum_q.pop_front();
                    last_sat = exp_sat_q.pop_front();
                    chk("sum", Datos_Sum, last_sum);
                    chk("sat_flag", sat_flag, last_sat);
                    chk("latency", exp_cyc_q.pop_front(), cyc);
                end
            end else begin
                chk("hold_sum", Datos_Sum, last_sum);
                chk("hold_sat", sat_flag, last_sat);
            end
            prev_sv = sum_valid;
        end
    end

    initial begin
        do_reset();

        // Basic frame: -0.75
        frame1(0);
        wait_drain();
        chk("t1_value", last_sum, 48'hFFD0_0000_0000);

        // Positive saturation
        repeat (4) put_pair(24'h7FFFFF, 24'h7FFFFF);
        wait_drain();
        chk("t2_value", last_sum, 48'h3FFF_FFFF_FFFF);
        chk("t2_sat", last_sat, 1'b1);

        // Negative saturation, then corner product
        repeat (4) put_pair(24'h7FFFFF, 24'h800000);
        wait_drain();
        chk("t3_value", last_sum, 48'hC000_0000_0000);
        put_pair(24'h800000, 24'h800000);
        repeat (3) put_pair(24'h000000, 24'h000000);
        wait_drain();
        chk("t3_corner", last_sum, 48'h3FFF_FFFF_FFFF);
        chk("t3_corner_sat", last_sat, 1'b1);

        // Gapped input
        frame1(3);
        wait_drain();
        chk("t4_value", last_sum, 48'hFFD0_0000_0000);
        chk("t4_sat", last_sat, 1'b0);

        // Reset mid-frame
        put_pair(24'h7FFFFF, 24'h7FFFFF);
        put_pair(24'h7FFFFF, 24'h7FFFFF);
        do_reset();
        frame1(0);
        wait_drain();
        chk("t5_value", last_sum, 48'hFFD0_0000_0000);

        // Back-to-back: saturating frame between clean ones, sticky must not leak
        pulse_q.delete();
        frame1(0);
        repeat (4) put_pair(24'h7FFFFF, 24'h7FFFFF);
        frame1(0);
        wait_drain();
        chk("t6_pulses", pulse_q.size(), 3);
        if (pulse_q.size() == 3) begin
            chk("t6_space1", pulse_q[1] - pulse_q[0], TAPS + 1);
            chk("t6_space2", pulse_q[2] - pulse_q[1], TAPS + 1);
        end
        chk("t6_sat_clear", last_sat, 1'b0);

        // Random frames
        for (int f = 0; f < 30; f++) begin
            for (int p = 0; p < TAPS; p++) begin
                logic [N-1:0] ra, rb;
                if ($urandom_range(0, 3) == 0) begin
                    ra = ($urandom_range(0, 1) != 0) ? 24'h7FFFFF : 24'h800000;
                    rb = ($urandom_range(0, 1) != 0) ? 24'h7FFFFF : 24'h800000;
                end else begin
                    ra = N'($urandom);
                    rb = N'($urandom);
                end
                put_pair(ra, rb);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
